// File: rtl/control_sequencer.sv
// Purpose: Moore control unit sequencing fetch (T0-T2) and per-opcode execute (T3-T7) for DataPath.
// Latency: one state per clock; strobes decode from registered state + latched opcode.
// Backpressure: memory states hold until mem_done; MEM_TIMEOUT waiting cycles force the sticky FAULT state.
// Ports: clock/clear (async active-low); ir, con, mem_done from DataPath/memory;
//        register strobes, gra/grb/grc/rin/rout/BAout selects, Read/Write, ops[4:0] to DataPath;
//        run (executing), fault (sticky timeout/illegal-opcode flag).
module control_sequencer #(
  parameter logic [4:0] OP_ADD      = 5'b00011,
  parameter int         MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        con,
  input  logic        mem_done,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        RZin,
  output logic        RZLOout,
  output logic        PCin,
  output logic        Read,
  output logic        Write,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        RYin,
  output logic        Cout,
  output logic        CONin,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        rin,
  output logic        rout,
  output logic        BAout,
  output logic [4:0]  ops,
  output logic        run,
  output logic        fault
);

  localparam logic [3:0] T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4;
  localparam logic [3:0] T5 = 4'd5, T6 = 4'd6, T7 = 4'd7, HALT = 4'd8, FAULT = 4'd9;

  localparam logic [4:0] OPC_LD   = 5'b00000, OPC_LDI  = 5'b00001, OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_ADD  = 5'b00011, OPC_SUB  = 5'b00100, OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110, OPC_ADDI = 5'b01100, OPC_ANDI = 5'b01101;
  localparam logic [4:0] OPC_ORI  = 5'b01110, OPC_BR   = 5'b10010, OPC_JR   = 5'b10011;
  localparam logic [4:0] OPC_NOP  = 5'b11000, OPC_HALT = 5'b11001;

  localparam int              CW      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0]   TO_LAST = CW'(MEM_TIMEOUT - 1);

  logic [3:0]    state_q, state_d;
  logic [4:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Low for the first edge after reset so that edge performs T0 rather than leaving it.
  logic          started_q;
  logic          mem_st;
  logic          unused_ir;

  assign unused_ir = ^ir[26:0];

  wire is_ldst = (op_q == OPC_LD) || (op_q == OPC_LDI) || (op_q == OPC_ST);
  wire is_alu  = (op_q >= OPC_ADD) && (op_q <= OPC_OR);
  wire is_imm  = (op_q >= OPC_ADDI) && (op_q <= OPC_ORI);

  // States that wait on the memory handshake.
  assign mem_st = started_q && ((state_q == T1) ||
                                (state_q == T6 && op_q == OPC_LD) ||
                                (state_q == T7 && op_q == OPC_ST));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      T0: state_d = T1;
      T1: if (mem_done) state_d = T2;
      T2: begin
        op_d = ir[31:27];
        case (ir[31:27])
          OPC_LD, OPC_LDI, OPC_ST, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
          OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_BR, OPC_JR: state_d = T3;
          OPC_NOP:  state_d = T0;
          OPC_HALT: state_d = HALT;
          default:  state_d = FAULT;
        endcase
      end
      T3: state_d = (op_q == OPC_JR) ? T0 : T4;
      T4: state_d = T5;
      T5: state_d = (op_q == OPC_LD || op_q == OPC_ST || op_q == OPC_BR) ? T6 : T0;
      T6: begin
        if (op_q == OPC_LD) begin
          if (mem_done) state_d = T7;
        end else if (op_q == OPC_ST) begin
          state_d = T7;
        end else begin
          state_d = T0;
        end
      end
      T7: begin
        if (op_q != OPC_ST || mem_done) state_d = T0;
      end
      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
    // Timeout fires on the last allowed waiting cycle, so Read/Write never exceed MEM_TIMEOUT cycles.
    if (mem_st && !mem_done && cnt_q == TO_LAST) state_d = FAULT;
    if (!started_q) begin
      state_d = state_q;
      op_d    = op_q;
    end
  end

  // Counter is zero on the first cycle of any memory state, which also marks the first T1 cycle.
  assign cnt_d = (mem_st && !mem_done && state_d == state_q) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= T0;
      op_q      <= '0;
      cnt_q     <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      started_q <= 1'b1;
    end
  end

  always_comb begin
    {PCout, MARin, IncPC, RZin, RZLOout, PCin, Read, Write, MDRin, MDRout} = '0;
    {IRin, RYin, Cout, CONin, gra, grb, grc, rin, rout, BAout}             = '0;
    ops = '0;
    if (started_q) begin
      case (state_q)
        T0: {PCout, MARin, IncPC, RZin} = '1;
        T1: begin
          Read  = 1'b1;
          MDRin = 1'b1;
          if (cnt_q == '0) {RZLOout, PCin} = '1;
        end
        T2: {MDRout, IRin} = '1;
        T3: begin
          if (is_ldst)                    {grb, BAout, RYin} = '1;
          else if (is_alu || is_imm)      {grb, rout, RYin}  = '1;
          else if (op_q == OPC_BR)        {gra, rout, CONin} = '1;
          else if (op_q == OPC_JR)        {gra, rout, PCin}  = '1;
        end
        T4: begin
          if (is_ldst) begin
            {Cout, RZin} = '1;
            ops = OP_ADD;
          end else if (is_alu) begin
            {grc, rout, RZin} = '1;
            ops = op_q;
          end else if (is_imm) begin
            {Cout, RZin} = '1;
            ops = (op_q == OPC_ANDI) ? OPC_AND : (op_q == OPC_ORI) ? OPC_OR : OP_ADD;
          end else if (op_q == OPC_BR) begin
            {PCout, RYin} = '1;
          end
        end
        T5: begin
          if (op_q == OPC_LD || op_q == OPC_ST) {RZLOout, MARin} = '1;
          else if (op_q == OPC_LDI || is_alu || is_imm) {RZLOout, gra, rin} = '1;
          else if (op_q == OPC_BR) begin
            {Cout, RZin} = '1;
            ops = OP_ADD;
          end
        end
        T6: begin
          if (op_q == OPC_LD)      {Read, MDRin} = '1;
          else if (op_q == OPC_ST) {gra, rout, MDRin} = '1;
          else if (op_q == OPC_BR && con) {RZLOout, PCin} = '1;
        end
        T7: begin
          if (op_q == OPC_LD)      {MDRout, gra, rin} = '1;
          else if (op_q == OPC_ST) Write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign run   = started_q && (state_q != HALT) && (state_q != FAULT);
  assign fault = (state_q == FAULT);

endmodule

// File: tb/tb_control_sequencer.sv
// Purpose: directed self-checking bench for control_sequencer (fetch, ld/st, memory wait, branch, ALU, halt, fault, reset).
// Latency: inputs change and outputs are sampled on the falling edge, half a cycle away from state updates.
// Backpressure: mem_done is driven per cycle from tables to stretch or starve the memory states.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        con;
  logic        mem_done;
  logic        PCout, MARin, IncPC, RZin, RZLOout, PCin, Read, Write, MDRin, MDRout;
  logic        IRin, RYin, Cout, CONin, gra, grb, grc, rin, rout, BAout;
  logic [4:0]  ops;
  logic        run, fault;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .con(con), .mem_done(mem_done),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .RZin(RZin), .RZLOout(RZLOout),
    .PCin(PCin), .Read(Read), .Write(Write), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .RYin(RYin), .Cout(Cout), .CONin(CONin), .gra(gra), .grb(grb),
    .grc(grc), .rin(rin), .rout(rout), .BAout(BAout), .ops(ops), .run(run), .fault(fault)
  );

  localparam logic [19:0] B_PCOUT = 20'h80000, B_MARIN  = 20'h40000, B_INCPC = 20'h20000;
  localparam logic [19:0] B_RZIN  = 20'h10000, B_RZLO   = 20'h08000, B_PCIN  = 20'h04000;
  localparam logic [19:0] B_READ  = 20'h02000, B_WRITE  = 20'h01000, B_MDRIN = 20'h00800;
  localparam logic [19:0] B_MDROUT= 20'h00400, B_IRIN   = 20'h00200, B_RYIN  = 20'h00100;
  localparam logic [19:0] B_COUT  = 20'h00080, B_CONIN  = 20'h00040, B_GRA   = 20'h00020;
  localparam logic [19:0] B_GRB   = 20'h00010, B_GRC    = 20'h00008, B_RIN   = 20'h00004;
  localparam logic [19:0] B_ROUT  = 20'h00002, B_BAOUT  = 20'h00001;

  localparam logic [19:0] S_T0  = B_PCOUT | B_MARIN | B_INCPC | B_RZIN;
  localparam logic [19:0] S_T1F = B_RZLO | B_PCIN | B_READ | B_MDRIN;
  localparam logic [19:0] S_T1W = B_READ | B_MDRIN;
  localparam logic [19:0] S_T2  = B_MDROUT | B_IRIN;
  localparam logic [19:0] S_LD3 = B_GRB | B_BAOUT | B_RYIN;
  localparam logic [19:0] S_LD4 = B_COUT | B_RZIN;
  localparam logic [19:0] S_LD5 = B_RZLO | B_MARIN;

  function automatic logic [19:0] strb();
    return {PCout, MARin, IncPC, RZin, RZLOout, PCin, Read, Write, MDRin, MDRout,
            IRin, RYin, Cout, CONin, gra, grb, grc, rin, rout, BAout};
  endfunction

  // Pulses reset and returns on the falling edge where T0 is first visible.
  task automatic do_reset(input logic [31:0] ir_v, input logic md, input logic con_v);
    ir = ir_v; mem_done = md; con = con_v;
    clear = 1'b0;
    @(negedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    clear = 1'b1; ir = '0; con = 1'b0; mem_done = 1'b0;
    #1 clear = 1'b0;
    repeat (2) @(negedge clock);
    n_chk++; if (strb() !== 20'h0) $display("FAIL reset_strobes got=%h want=0", strb()); else n_pass++;
    n_chk++; if (ops !== 5'd0) $display("FAIL reset_ops got=%b want=00000", ops); else n_pass++;
    n_chk++; if (run !== 1'b0) $display("FAIL reset_run got=%b want=0", run); else n_pass++;
    n_chk++; if (fault !== 1'b0) $display("FAIL reset_fault got=%b want=0", fault); else n_pass++;
    clear = 1'b1;
    #1;
    n_chk++; if (strb() !== 20'h0) $display("FAIL release_before_edge got=%h want=0", strb()); else n_pass++;
    @(negedge clock);
    n_chk++; if (strb() !== S_T0) $display("FAIL first_T0 got=%h want=%h", strb(), S_T0); else n_pass++;
    n_chk++; if (run !== 1'b1) $display("FAIL first_T0_run got=%b want=1", run); else n_pass++;
  endtask

  task automatic test_fetch_ld();
    logic [19:0] exp [9];
    exp = '{S_T0, S_T1F, S_T2, S_LD3, S_LD4, S_LD5, S_T1W, B_MDROUT | B_GRA | B_RIN, S_T0};
    do_reset(32'h00900054, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      n_chk++;
      if (strb() !== exp[i]) $display("FAIL ld_step%0d got=%h want=%h", i, strb(), exp[i]);
      else n_pass++;
      if (i == 4) begin
        n_chk++; if (ops !== 5'b00011) $display("FAIL ld_T4_ops got=%b want=00011", ops); else n_pass++;
      end
      if (i < 8) @(negedge clock);
    end
  endtask

  task automatic test_mem_wait();
    logic [19:0] exp [15];
    logic        md  [15];
    exp = '{S_T0, S_T1F, S_T1W, S_T1W, S_T1W, S_T2, S_LD3, S_LD4, S_LD5,
            S_T1W, S_T1W, S_T1W, S_T1W, B_MDROUT | B_GRA | B_RIN, S_T0};
    md  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
            1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset(32'h00900054, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      mem_done = md[i];
      n_chk++;
      if (strb() !== exp[i]) $display("FAIL memwait_step%0d got=%h want=%h", i, strb(), exp[i]);
      else n_pass++;
      if (i < 14) @(negedge clock);
    end
  endtask

  task automatic test_st_timeout();
    logic [19:0] exp [7];
    exp = '{S_T0, S_T1F, S_T2, S_LD3, S_LD4, S_LD5, B_GRA | B_ROUT | B_MDRIN};
    do_reset(32'h10900054, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      n_chk++;
      if (strb() !== exp[i]) $display("FAIL st_step%0d got=%h want=%h", i, strb(), exp[i]);
      else n_pass++;
      @(negedge clock);
    end
    mem_done = 1'b0;
    for (int k = 0; k < 15; k++) begin
      n_chk++;
      if (strb() !== B_WRITE) $display("FAIL st_T7_wait%0d got=%h want=%h", k, strb(), B_WRITE);
      else n_pass++;
      @(negedge clock);
    end
    n_chk++; if (strb() !== 20'h0) $display("FAIL timeout_strobes got=%h want=0", strb()); else n_pass++;
    n_chk++; if (fault !== 1'b1) $display("FAIL timeout_fault got=%b want=1", fault); else n_pass++;
    n_chk++; if (run !== 1'b0) $display("FAIL timeout_run got=%b want=0", run); else n_pass++;
    mem_done = 1'b1;
    repeat (3) @(negedge clock);
    n_chk++; if (fault !== 1'b1 || strb() !== 20'h0)
      $display("FAIL fault_sticky got fault=%b strobes=%h want fault=1 strobes=0", fault, strb());
    else n_pass++;
  endtask

  task automatic test_branch(input logic con_v);
    logic [19:0] exp [8];
    exp = '{S_T0, S_T1F, S_T2, B_GRA | B_ROUT | B_CONIN, B_PCOUT | B_RYIN, S_LD4,
            con_v ? (B_RZLO | B_PCIN) : 20'h0, S_T0};
    do_reset(32'h90000000, 1'b1, con_v);
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (strb() !== exp[i]) $display("FAIL br_con%0b_step%0d got=%h want=%h", con_v, i, strb(), exp[i]);
      else n_pass++;
      if (i == 5) begin
        n_chk++; if (ops !== 5'b00011) $display("FAIL br_T5_ops got=%b want=00011", ops); else n_pass++;
      end
      if (i < 7) @(negedge clock);
    end
  endtask

  task automatic test_alu(input logic [31:0] ir_v, input logic [19:0] exp4, input logic [4:0] ops4);
    logic [19:0] exp [7];
    exp = '{S_T0, S_T1F, S_T2, B_GRB | B_ROUT | B_RYIN, exp4, B_RZLO | B_GRA | B_RIN, S_T0};
    do_reset(ir_v, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      n_chk++;
      if (strb() !== exp[i]) $display("FAIL alu_%h_step%0d got=%h want=%h", ir_v, i, strb(), exp[i]);
      else n_pass++;
      if (i == 4) begin
        n_chk++; if (ops !== ops4) $display("FAIL alu_%h_T4_ops got=%b want=%b", ir_v, ops, ops4); else n_pass++;
      end
      if (i < 6) @(negedge clock);
    end
  endtask

  task automatic test_halt();
    do_reset(32'hC8000000, 1'b1, 1'b0);
    repeat (2) @(negedge clock);
    n_chk++; if (strb() !== S_T2) $display("FAIL halt_T2 got=%h want=%h", strb(), S_T2); else n_pass++;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      n_chk++;
      if (strb() !== 20'h0 || ops !== 5'd0 || run !== 1'b0 || fault !== 1'b0)
        $display("FAIL halt_cycle%0d got strobes=%h ops=%b run=%b fault=%b want all 0",
                 k, strb(), ops, run, fault);
      else n_pass++;
    end
  endtask

  task automatic test_illegal();
    do_reset(32'hF8000000, 1'b1, 1'b0);
    repeat (3) @(negedge clock);
    n_chk++; if (fault !== 1'b1) $display("FAIL illegal_fault got=%b want=1", fault); else n_pass++;
    n_chk++; if (run !== 1'b0) $display("FAIL illegal_run got=%b want=0", run); else n_pass++;
    n_chk++; if (strb() !== 20'h0) $display("FAIL illegal_strobes got=%h want=0", strb()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset(32'h00900054, 1'b1, 1'b0);
    repeat (5) @(negedge clock);
    n_chk++; if (strb() !== S_LD5) $display("FAIL mid_T5 got=%h want=%h", strb(), S_LD5); else n_pass++;
    #2 clear = 1'b0;
    #1;
    n_chk++; if (strb() !== 20'h0 || run !== 1'b0 || ops !== 5'd0)
      $display("FAIL mid_reset_async got strobes=%h run=%b ops=%b want all 0", strb(), run, ops);
    else n_pass++;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    n_chk++; if (strb() !== S_T0 || run !== 1'b1)
      $display("FAIL mid_reset_T0 got strobes=%h run=%b want %h run=1", strb(), run, S_T0);
    else n_pass++;
    @(negedge clock);
    n_chk++; if (strb() !== S_T1F) $display("FAIL mid_reset_T1 got=%h want=%h", strb(), S_T1F); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fetch_ld();
    test_mem_wait();
    test_st_timeout();
    test_branch(1'b0);
    test_branch(1'b1);
    test_alu(32'h18950000, B_GRC | B_ROUT | B_RZIN, 5'b00011);
    test_alu(32'h68900007, B_COUT | B_RZIN, 5'b00101);
    test_halt();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
